// File: rtl/hazard_ctrl_if.sv
// -----------------------------------------------------------------------------
// hazard_ctrl_if
// Bundle of every signal exchanged between the pipeline datapath and the
// hazard controller.
//   master : datapath side - drives register numbers, stage controls and the
//            mult/div request; receives the stall/flush/forward/md controls.
//   slave  : hazard controller side - the reverse directions.
// -----------------------------------------------------------------------------
interface hazard_ctrl_if;
    // Stage source / destination register numbers
    logic [4:0] rs_d;
    logic [4:0] rt_d;
    logic [4:0] rs_e;
    logic [4:0] rt_e;
    logic [4:0] writereg_e;
    logic [4:0] writereg_m;
    logic [4:0] writereg_w;
    // Stage controls
    logic       regwrite_e;
    logic       regwrite_m;
    logic       regwrite_w;
    logic       memtoreg_e;
    logic       memtoreg_m;
    logic       branch_d;
    logic       pcsrc_d;
    logic       md_start_e;
    logic       md_is_div_e;
    // Pipeline controls back to the datapath
    logic       stall_f;
    logic       stall_d;
    logic       stall_e;
    logic       flush_d;
    logic       flush_e;
    logic       flush_m;
    logic       forward_a_d;
    logic       forward_b_d;
    logic [1:0] forward_a_e;
    logic [1:0] forward_b_e;
    logic       md_busy;
    logic       md_done;

    modport master (
        output rs_d, rt_d, rs_e, rt_e, writereg_e, writereg_m, writereg_w,
        output regwrite_e, regwrite_m, regwrite_w, memtoreg_e, memtoreg_m,
        output branch_d, pcsrc_d, md_start_e, md_is_div_e,
        input  stall_f, stall_d, stall_e, flush_d, flush_e, flush_m,
        input  forward_a_d, forward_b_d, forward_a_e, forward_b_e,
        input  md_busy, md_done
    );

    modport slave (
        input  rs_d, rt_d, rs_e, rt_e, writereg_e, writereg_m, writereg_w,
        input  regwrite_e, regwrite_m, regwrite_w, memtoreg_e, memtoreg_m,
        input  branch_d, pcsrc_d, md_start_e, md_is_div_e,
        output stall_f, stall_d, stall_e, flush_d, flush_e, flush_m,
        output forward_a_d, forward_b_d, forward_a_e, forward_b_e,
        output md_busy, md_done
    );
endinterface

// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
// Hazard controller for the 5-stage MIPS pipeline: load-use and branch-operand
// stalls, redirect flush, EX/D-stage forwarding selects, and a mult/div
// occupancy FSM that holds the pipeline while the HI/LO unit is busy.
// Ports:
//   clk : clock, FSM advances on the rising edge
//   rst : asynchronous active-high reset; forces every output to 0 while high
//   hz  : hazard_ctrl_if.slave - stage inputs in, stall/flush/forward/md out
// All outputs except md_done are combinational from inputs and FSM state;
// md_done is a Moore output of the DONE state.
// -----------------------------------------------------------------------------
module hazard_ctrl #(
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 32,
    parameter int CNT_W   = 6
) (
    input  logic          clk,
    input  logic          rst,
    hazard_ctrl_if.slave  hz
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } md_state_t;

    // The request cycle in IDLE is the first stalled cycle, so BUSY only
    // needs to cover LAT-1 more cycles: load LAT-2 and leave at cnt==0.
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 2);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LAT - 2);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    md_state_t        state_r;
    md_state_t        state_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_s;
    logic             lw_stall_s;
    logic             br_stall_s;
    logic             md_stall_s;
    logic             stall_any_s;

    // Register 0 is hard-wired zero, so it never creates a dependency.
    function automatic logic reg_match(input logic [4:0] a, input logic [4:0] b);
        return (a != 5'd0) && (a == b);
    endfunction

    // EX-stage operand select: the younger MEM result beats the WB result.
    function automatic logic [1:0] fwd_sel_e(input logic [4:0] src,
                                             input logic       rw_m,
                                             input logic [4:0] wr_m,
                                             input logic       rw_w,
                                             input logic [4:0] wr_w);
        if (rw_m && reg_match(wr_m, src)) begin
            return 2'b10;
        end else if (rw_w && reg_match(wr_w, src)) begin
            return 2'b01;
        end else begin
            return 2'b00;
        end
    endfunction

    // Hazard detection: load-use, branch operand not yet available, mult/div hold.
    always_comb begin
        lw_stall_s = hz.memtoreg_e & hz.regwrite_e &
                     (reg_match(hz.writereg_e, hz.rs_d) | reg_match(hz.writereg_e, hz.rt_d));
        br_stall_s = hz.branch_d &
                     ((hz.regwrite_e &
                       (reg_match(hz.writereg_e, hz.rs_d) | reg_match(hz.writereg_e, hz.rt_d))) |
                      (hz.memtoreg_m &
                       (reg_match(hz.writereg_m, hz.rs_d) | reg_match(hz.writereg_m, hz.rt_d))));
        md_stall_s = ((state_r == IDLE) & hz.md_start_e) | (state_r == BUSY);
        stall_any_s = md_stall_s | lw_stall_s | br_stall_s;
    end

    // Occupancy FSM next state; DONE always returns to IDLE so a request
    // still present in DONE cannot restart the unit.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        case (state_r)
            IDLE: begin
                if (hz.md_start_e) begin
                    state_s = BUSY;
                    cnt_s   = hz.md_is_div_e ? DIV_LOAD : MUL_LOAD;
                end else begin
                    state_s = IDLE;
                    cnt_s   = cnt_r;
                end
            end
            BUSY: begin
                if (cnt_r == CNT_ZERO) begin
                    state_s = DONE;
                    cnt_s   = cnt_r;
                end else begin
                    state_s = BUSY;
                    cnt_s   = cnt_r - CNT_ONE;
                end
            end
            DONE: begin
                state_s = IDLE;
                cnt_s   = cnt_r;
            end
            default: begin
                state_s = IDLE;
                cnt_s   = CNT_ZERO;
            end
        endcase
    end

    // Occupancy FSM state and counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            cnt_r   <= CNT_ZERO;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
        end
    end

    // Pipeline control outputs; a stalled register is never also flushed,
    // and a stall holds a redirect until it can be re-evaluated.
    always_comb begin
        hz.stall_f     = 1'b0;
        hz.stall_d     = 1'b0;
        hz.stall_e     = 1'b0;
        hz.flush_d     = 1'b0;
        hz.flush_e     = 1'b0;
        hz.flush_m     = 1'b0;
        hz.forward_a_d = 1'b0;
        hz.forward_b_d = 1'b0;
        hz.forward_a_e = 2'b00;
        hz.forward_b_e = 2'b00;
        hz.md_busy     = 1'b0;
        hz.md_done     = 1'b0;
        if (rst) begin
            hz.stall_f = 1'b0;
        end else begin
            hz.stall_f     = stall_any_s;
            hz.stall_d     = stall_any_s;
            hz.stall_e     = md_stall_s;
            hz.flush_d     = hz.pcsrc_d & ~stall_any_s;
            hz.flush_e     = (lw_stall_s | br_stall_s) & ~md_stall_s;
            hz.flush_m     = md_stall_s;
            hz.forward_a_d = hz.regwrite_m & reg_match(hz.writereg_m, hz.rs_d);
            hz.forward_b_d = hz.regwrite_m & reg_match(hz.writereg_m, hz.rt_d);
            hz.forward_a_e = fwd_sel_e(hz.rs_e, hz.regwrite_m, hz.writereg_m,
                                       hz.regwrite_w, hz.writereg_w);
            hz.forward_b_e = fwd_sel_e(hz.rt_e, hz.regwrite_m, hz.writereg_m,
                                       hz.regwrite_w, hz.writereg_w);
            hz.md_busy     = md_stall_s;
            hz.md_done     = (state_r == DONE);
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl
// Self-checking bench for hazard_ctrl. A behavioural model (hazard rules as
// boolean equations, mult/div occupancy as a remaining-stall-cycles counter)
// predicts the full output vector each cycle. Inputs change 1 time unit after
// the rising edge; outputs are compared on the falling edge.
// -----------------------------------------------------------------------------
module tb_hazard_ctrl;
    localparam int MUL_LAT = 4;
    localparam int DIV_LAT = 32;
    localparam int CNT_W   = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    hazard_ctrl_if hif();

    hazard_ctrl #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hif)
    );

    int chk_cnt  = 0;
    int pass_cnt = 0;

    // Model state: stalled cycles still to come, and whether this cycle is the
    // single result cycle that follows them.
    int busy_left = 0;
    bit done_now  = 1'b0;

    // Observed outputs packed in a fixed order:
    // stall_f stall_d stall_e flush_d flush_e flush_m fwd_a_d fwd_b_d fwd_a_e fwd_b_e md_busy md_done
    logic [14:0] act;
    assign act = {hif.stall_f, hif.stall_d, hif.stall_e, hif.flush_d, hif.flush_e, hif.flush_m,
                  hif.forward_a_d, hif.forward_b_d, hif.forward_a_e, hif.forward_b_e,
                  hif.md_busy, hif.md_done};

    // Occupancy model update.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_left <= 0;
            done_now  <= 1'b0;
        end else if (busy_left > 0) begin
            busy_left <= busy_left - 1;
            if (busy_left == 1) done_now <= 1'b1;
        end else if (done_now) begin
            done_now <= 1'b0;
        end else if (hif.md_start_e) begin
            busy_left <= hif.md_is_div_e ? DIV_LAT - 1 : MUL_LAT - 1;
        end
    end

    function automatic bit m(input logic [4:0] a, input logic [4:0] b);
        return (a != 5'd0) && (a == b);
    endfunction

    function automatic logic [1:0] fe(input logic [4:0] src);
        if (hif.regwrite_m && m(hif.writereg_m, src)) return 2'b10;
        if (hif.regwrite_w && m(hif.writereg_w, src)) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [14:0] exp_out();
        bit ms, lw, br, st;
        if (rst) return 15'd0;
        ms = (busy_left > 0) || (!done_now && hif.md_start_e);
        lw = hif.memtoreg_e && hif.regwrite_e && (m(hif.writereg_e, hif.rs_d) || m(hif.writereg_e, hif.rt_d));
        br = hif.branch_d &&
             ((hif.regwrite_e && (m(hif.writereg_e, hif.rs_d) || m(hif.writereg_e, hif.rt_d))) ||
              (hif.memtoreg_m && (m(hif.writereg_m, hif.rs_d) || m(hif.writereg_m, hif.rt_d))));
        st = ms || lw || br;
        return {st, st, ms, hif.pcsrc_d && !st, (lw || br) && !ms, ms,
                hif.regwrite_m && m(hif.writereg_m, hif.rs_d),
                hif.regwrite_m && m(hif.writereg_m, hif.rt_d),
                fe(hif.rs_e), fe(hif.rt_e), ms, done_now};
    endfunction

    task automatic clear_inputs();
        hif.rs_d = 5'd0; hif.rt_d = 5'd0; hif.rs_e = 5'd0; hif.rt_e = 5'd0;
        hif.writereg_e = 5'd0; hif.writereg_m = 5'd0; hif.writereg_w = 5'd0;
        hif.regwrite_e = 1'b0; hif.regwrite_m = 1'b0; hif.regwrite_w = 1'b0;
        hif.memtoreg_e = 1'b0; hif.memtoreg_m = 1'b0;
        hif.branch_d = 1'b0; hif.pcsrc_d = 1'b0;
        hif.md_start_e = 1'b0; hif.md_is_div_e = 1'b0;
    endtask

    task automatic rand_inputs();
        hif.rs_d = 5'($urandom_range(3, 0)); hif.rt_d = 5'($urandom_range(3, 0));
        hif.rs_e = 5'($urandom_range(3, 0)); hif.rt_e = 5'($urandom_range(3, 0));
        hif.writereg_e = 5'($urandom_range(3, 0));
        hif.writereg_m = 5'($urandom_range(3, 0));
        hif.writereg_w = 5'($urandom_range(3, 0));
        hif.regwrite_e = 1'($urandom); hif.regwrite_m = 1'($urandom); hif.regwrite_w = 1'($urandom);
        hif.memtoreg_e = 1'($urandom); hif.memtoreg_m = 1'($urandom);
        hif.branch_d = 1'($urandom); hif.pcsrc_d = 1'($urandom);
        hif.md_start_e = ($urandom_range(7, 0) == 0);
        hif.md_is_div_e = ($urandom_range(3, 0) == 0);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [14:0] e;
        for (int i = 0; i < 3; i++) begin
            rand_inputs();
            hif.md_start_e = 1'b1;
            @(negedge clk);
            e = exp_out();
            chk_cnt++;
            if (act !== 15'd0 || act !== e) $display("FAIL reset_outputs: got %b expected %b", act, 15'd0);
            else pass_cnt++;
            next_cycle();
        end
        clear_inputs();
        rst = 1'b0;
        next_cycle();
    endtask

    task automatic test_lw_stall();
        logic [14:0] e;
        clear_inputs();
        hif.memtoreg_e = 1'b1; hif.regwrite_e = 1'b1; hif.writereg_e = 5'd2; hif.rs_d = 5'd2;
        @(negedge clk);
        e = exp_out();
        chk_cnt++;
        if (act !== e || {hif.stall_f, hif.stall_d, hif.flush_e} !== 3'b111)
            $display("FAIL lw_stall: got %b expected %b", act, e);
        else pass_cnt++;
        next_cycle();
        clear_inputs();
        hif.memtoreg_m = 1'b1; hif.regwrite_m = 1'b1; hif.writereg_m = 5'd2; hif.rs_e = 5'd2;
        @(negedge clk);
        e = exp_out();
        chk_cnt++;
        if (act !== e || hif.forward_a_e !== 2'b10 || hif.stall_d !== 1'b0)
            $display("FAIL lw_forward: got %b expected %b", act, e);
        else pass_cnt++;
        next_cycle();
    endtask

    task automatic test_forward();
        logic [14:0] e;
        clear_inputs();
        hif.writereg_m = 5'd5; hif.writereg_w = 5'd5; hif.regwrite_m = 1'b1; hif.regwrite_w = 1'b1;
        hif.rs_e = 5'd5;
        @(negedge clk);
        e = exp_out();
        chk_cnt++;
        if (act !== e || hif.forward_a_e !== 2'b10) $display("FAIL fwd_mem_priority: got %b expected %b", act, e);
        else pass_cnt++;
        next_cycle();
        hif.writereg_m = 5'd0; hif.writereg_w = 5'd0; hif.rs_e = 5'd0;
        @(negedge clk);
        e = exp_out();
        chk_cnt++;
        if (act !== e || hif.forward_a_e !== 2'b00) $display("FAIL fwd_reg0: got %b expected %b", act, e);
        else pass_cnt++;
        next_cycle();
        hif.writereg_m = 5'd3; hif.writereg_w = 5'd7; hif.rt_e = 5'd7; hif.rt_d = 5'd3;
        @(negedge clk);
        e = exp_out();
        chk_cnt++;
        if (act !== e || hif.forward_b_e !== 2'b01 || hif.forward_b_d !== 1'b1)
            $display("FAIL fwd_wb_and_d: got %b expected %b", act, e);
        else pass_cnt++;
        next_cycle();
    endtask

    task automatic test_mul();
        logic [14:0] e;
        int nb = 0;
        int nd = 0;
        bit seen = 1'b0;
        clear_inputs();
        hif.md_start_e = 1'b1; hif.md_is_div_e = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            e = exp_out();
            chk_cnt++;
            if (act !== e) $display("FAIL mul_cycle%0d: got %b expected %b", i, act, e);
            else pass_cnt++;
            if (hif.md_busy === 1'b1) nb++;
            if (hif.md_done === 1'b1) begin
                nd++;
                seen = 1'b1;
                chk_cnt++;
                if ({hif.stall_f, hif.stall_d, hif.stall_e} !== 3'b000)
                    $display("FAIL mul_done_stalls: got %b expected 000", {hif.stall_f, hif.stall_d, hif.stall_e});
                else pass_cnt++;
            end
            next_cycle();
            if (seen) hif.md_start_e = 1'b0;
        end
        chk_cnt++;
        if (nb !== MUL_LAT || nd !== 1) $display("FAIL mul_counts: got busy=%0d done=%0d expected busy=%0d done=1", nb, nd, MUL_LAT);
        else pass_cnt++;
    endtask

    task automatic test_div_lw();
        logic [14:0] e;
        bit seen = 1'b0;
        clear_inputs();
        hif.md_start_e = 1'b1; hif.md_is_div_e = 1'b1;
        for (int i = 0; i < 10; i++) next_cycle();
        hif.memtoreg_e = 1'b1; hif.regwrite_e = 1'b1; hif.writereg_e = 5'd4; hif.rs_d = 5'd4;
        @(negedge clk);
        e = exp_out();
        chk_cnt++;
        if (act !== e || hif.flush_e !== 1'b0 || hif.stall_d !== 1'b1)
            $display("FAIL div_lw_no_flush: got %b expected %b", act, e);
        else pass_cnt++;
        for (int i = 0; i < 40 && !seen; i++) begin
            next_cycle();
            @(negedge clk);
            e = exp_out();
            chk_cnt++;
            if (act !== e) $display("FAIL div_lw_cycle%0d: got %b expected %b", i, act, e);
            else pass_cnt++;
            if (hif.md_done === 1'b1) seen = 1'b1;
        end
        chk_cnt++;
        if (!seen) $display("FAIL div_done_timeout: got no md_done expected md_done within bound");
        else pass_cnt++;
        next_cycle();
        hif.md_start_e = 1'b0;
        @(negedge clk);
        e = exp_out();
        chk_cnt++;
        if (act !== e || hif.flush_e !== 1'b1 || hif.stall_d !== 1'b1)
            $display("FAIL lw_after_div: got %b expected %b", act, e);
        else pass_cnt++;
        next_cycle();
    endtask

    task automatic test_branch_redirect();
        logic [14:0] e;
        clear_inputs();
        hif.branch_d = 1'b1; hif.pcsrc_d = 1'b1; hif.regwrite_e = 1'b1; hif.writereg_e = 5'd6; hif.rs_d = 5'd6;
        @(negedge clk);
        e = exp_out();
        chk_cnt++;
        if (act !== e || hif.flush_d !== 1'b0 || hif.stall_d !== 1'b1)
            $display("FAIL br_stall_wins: got %b expected %b", act, e);
        else pass_cnt++;
        next_cycle();
        hif.regwrite_e = 1'b0; hif.writereg_e = 5'd0;
        @(negedge clk);
        e = exp_out();
        chk_cnt++;
        if (act !== e || hif.flush_d !== 1'b1 || hif.stall_d !== 1'b0)
            $display("FAIL br_redirect: got %b expected %b", act, e);
        else pass_cnt++;
        next_cycle();
        hif.pcsrc_d = 1'b0; hif.memtoreg_m = 1'b1; hif.regwrite_m = 1'b1; hif.writereg_m = 5'd9; hif.rt_d = 5'd9;
        @(negedge clk);
        e = exp_out();
        chk_cnt++;
        if (act !== e || hif.flush_e !== 1'b1 || hif.forward_b_d !== 1'b1)
            $display("FAIL br_load_in_mem: got %b expected %b", act, e);
        else pass_cnt++;
        next_cycle();
    endtask

    task automatic test_reset_mid_div();
        logic [14:0] e;
        int nb = 0;
        bit seen = 1'b0;
        clear_inputs();
        hif.md_start_e = 1'b1; hif.md_is_div_e = 1'b1;
        for (int i = 0; i < 10; i++) next_cycle();
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        e = exp_out();
        chk_cnt++;
        if (act !== 15'd0 || act !== e) $display("FAIL rst_mid_div: got %b expected %b", act, 15'd0);
        else pass_cnt++;
        next_cycle();
        rst = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            e = exp_out();
            chk_cnt++;
            if (act !== e) $display("FAIL div_after_rst%0d: got %b expected %b", i, act, e);
            else pass_cnt++;
            if (hif.md_busy === 1'b1) nb++;
            if (hif.md_done === 1'b1) seen = 1'b1;
            next_cycle();
            if (seen) hif.md_start_e = 1'b0;
        end
        chk_cnt++;
        if (nb !== DIV_LAT) $display("FAIL div_stall_count: got %0d expected %0d", nb, DIV_LAT);
        else pass_cnt++;
    endtask

    task automatic test_random();
        logic [14:0] e;
        for (int i = 0; i < 400; i++) begin
            rand_inputs();
            rst = ($urandom_range(49, 0) == 0);
            @(negedge clk);
            e = exp_out();
            chk_cnt++;
            if (act !== e) $display("FAIL random%0d: got %b expected %b", i, act, e);
            else pass_cnt++;
            next_cycle();
        end
        rst = 1'b0;
        clear_inputs();
        next_cycle();
    endtask

    initial begin
        clear_inputs();
        #1;
        test_reset();
        test_lw_stall();
        test_forward();
        test_mul();
        test_div_lw();
        test_branch_redirect();
        test_reset_mid_div();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
